// File: rtl/pwm_capture_if.sv
// Decoded-speed bus from pwm_capture to a servo control block, plus FSM state for observation.
// speed_valid is a one-cycle strobe without a ready: the consumer must take speed when it is high.
interface pwm_capture_if;
  logic [7:0]  speed;
  logic        speed_valid;
  logic [31:0] pulse_width;
  logic [31:0] period;
  logic        signal_lost;
  logic [1:0]  state;

  modport master (output speed, speed_valid, pulse_width, period, signal_lost, state);
  modport slave  (input  speed, speed_valid, pulse_width, period, signal_lost, state);
endinterface

// File: rtl/pwm_capture.sv
// Measures the high time of an incoming PWM pulse and decodes it to an 8-bit speed code.
// Optional glitch filter on the synchronized input: define PWM_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int unsigned MIN_PULSE  = 50000,
  parameter int unsigned MAX_PULSE  = 100000,
  parameter int unsigned TIMEOUT    = 2000000,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PWM_IN,
  pwm_capture_if.master cap
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  HIGH  = 2'd1;
  localparam logic [1:0]  LOW   = 2'd2;
  localparam logic [31:0] MIN_P = MIN_PULSE;
  localparam logic [31:0] MAX_P = MAX_PULSE;
  localparam logic [31:0] TMO   = TIMEOUT;
  localparam logic [39:0] SPAN  = 40'(MAX_PULSE - MIN_PULSE);

  logic [1:0]  sync_q;
  logic        lvl;
  logic        prev_lvl;
  logic        rise;
  logic        fall;
  logic [1:0]  state;
  logic [31:0] hi_cnt;
  logic [31:0] per_cnt;
  logic [31:0] hi_inc;
  logic [31:0] per_inc;
  logic        timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], PWM_IN};
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] flt_cnt;
  logic          flt_q;

  // The filtered level flips combinationally on the FILTER_LEN-th differing sample,
  // so the added delay is exactly FILTER_LEN-1 cycles on both edges.
  always_comb begin
    lvl = flt_q;
    if (sync_q[1] != flt_q && flt_cnt == CW'(FILTER_LEN - 1)) lvl = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_q   <= 1'b0;
      flt_cnt <= '0;
    end else begin
      flt_q <= lvl;
      if (sync_q[1] == flt_q || lvl != flt_q) flt_cnt <= '0;
      else                                    flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign prev_lvl = flt_q;
`else
  logic lvl_q;

  assign lvl = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) lvl_q <= 1'b0;
    else        lvl_q <= lvl;
  end

  assign prev_lvl = lvl_q;
`endif

  assign rise    = lvl & ~prev_lvl;
  assign fall    = ~lvl & prev_lvl;
  assign hi_inc  = (hi_cnt  == 32'hFFFF_FFFF) ? hi_cnt  : hi_cnt  + 32'd1;
  assign per_inc = (per_cnt == 32'hFFFF_FFFF) ? per_cnt : per_cnt + 32'd1;
  assign timeout = (state != IDLE) && (per_cnt >= TMO);

  function automatic logic [7:0] decode(input logic [31:0] h);
    logic [39:0] q;
    q = '0;
    if (h <= MIN_P) begin
      decode = 8'd0;
    end else if (h >= MAX_P) begin
      decode = 8'hFF;
    end else begin
      q = ({8'd0, h - MIN_P} << 8) / SPAN;
      decode = (q > 40'd255) ? 8'hFF : q[7:0];
    end
  endfunction

  // Timeout has priority over any edge seen in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      hi_cnt          <= '0;
      per_cnt         <= '0;
      cap.speed       <= '0;
      cap.speed_valid <= 1'b0;
      cap.pulse_width <= '0;
      cap.period      <= '0;
      cap.signal_lost <= 1'b1;
    end else begin
      cap.speed_valid <= 1'b0;
      if (timeout) begin
        cap.signal_lost <= 1'b1;
        state           <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              hi_cnt  <= 32'd1;
              per_cnt <= 32'd1;
              state   <= HIGH;
            end
          end
          HIGH: begin
            hi_cnt  <= hi_inc;
            per_cnt <= per_inc;
            if (fall) begin
              cap.pulse_width <= hi_cnt;
              cap.speed       <= decode(hi_cnt);
              cap.speed_valid <= 1'b1;
              cap.signal_lost <= 1'b0;
              state           <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              cap.period <= per_cnt;
              hi_cnt     <= 32'd1;
              per_cnt    <= 32'd1;
              state      <= HIGH;
            end else begin
              per_cnt <= per_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cap.state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: vector table for pulse decoding plus timeout and mid-pulse reset sequences.
module tb_pwm_capture;

  localparam int MIN_PULSE  = 500;
  localparam int MAX_PULSE  = 1000;
  localparam int TIMEOUT    = 20000;
  localparam int FILTER_LEN = 4;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int LAT        = 3 + FILTER_LEN - 1;
  localparam int PER_AFTER4 = 8004;
`else
  localparam int LAT        = 3;
  localparam int PER_AFTER4 = 1003;
`endif

  typedef struct {
    int       width;
    int       low;
    bit       strobe;
    logic [7:0] speed;
    int       pw;
    int       per;
  } vec_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pwm_in = 1'b0;
  int   cyc    = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [39:0] exp_q[$];
  vec_t vecs[11];

  pwm_capture_if cap_if();

  pwm_capture #(
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE),
    .TIMEOUT   (TIMEOUT),
    .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .PWM_IN(pwm_in),
    .cap   (cap_if)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got no finish expected finish before 100000 cycles");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: high for width cycles, then low for low cycles (low >= 1); period = width + low
  task automatic pulse(input int width, input int low);
    @(posedge clk); #1 pwm_in = 1'b1; rise_cyc = cyc;
    repeat (width) @(posedge clk);
    #1 pwm_in = 1'b0; fall_cyc = cyc;
    repeat (low - 1) @(posedge clk);
  endtask

  // scoreboard: every strobe must match the head of exp_q and come LAT cycles after the fall
  always @(negedge clk) begin
    if (cap_if.speed_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("strobe_speed", 64'(cap_if.speed), 64'(e[39:32]));
        check("strobe_pulse_width", 64'(cap_if.pulse_width), 64'(e[31:0]));
        check("strobe_latency", 64'(cyc - fall_cyc), 64'(LAT));
        check("strobe_signal_lost", 64'(cap_if.signal_lost), 64'd0);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_speed"}, 64'(cap_if.speed), 64'd0);
    check({tag, "_pulse_width"}, 64'(cap_if.pulse_width), 64'd0);
    check({tag, "_period"}, 64'(cap_if.period), 64'd0);
    check({tag, "_signal_lost"}, 64'(cap_if.signal_lost), 64'd1);
    check({tag, "_state"}, 64'(cap_if.state), 64'd0);
  endtask

  initial begin
    int lost_cyc;

    vecs[0]  = '{750, 9250, 1'b1, 8'd128, 750, 0};
    vecs[1]  = '{750, 9250, 1'b1, 8'd128, 750, 10000};
    vecs[2]  = '{750, 9250, 1'b1, 8'd128, 750, 10000};
    vecs[3]  = '{400, 1000, 1'b1, 8'd0, 400, 10000};
    vecs[4]  = '{500, 1000, 1'b1, 8'd0, 500, 1400};
    vecs[5]  = '{600, 1000, 1'b1, 8'd51, 600, 1500};
    vecs[6]  = '{999, 1000, 1'b1, 8'd255, 999, 1600};
    vecs[7]  = '{1000, 1000, 1'b1, 8'd255, 1000, 1999};
    vecs[8]  = '{5000, 1000, 1'b1, 8'd255, 5000, 2000};
`ifdef PWM_GLITCH_FILTER_EN
    vecs[9]  = '{1, 1000, 1'b0, 8'd255, 5000, 2000};
    vecs[10] = '{3, 1000, 1'b0, 8'd255, 5000, 2000};
`else
    vecs[9]  = '{1, 1000, 1'b1, 8'd0, 1, 6000};
    vecs[10] = '{3, 1000, 1'b1, 8'd0, 3, 1001};
`endif

    // reset state
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // pulse table: nominal, boundary widths, glitches
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].strobe) exp_q.push_back({vecs[i].speed, 32'(vecs[i].width)});
      pulse(vecs[i].width, vecs[i].low);
      @(negedge clk);
      check($sformatf("vec%0d_pending", i), 64'(exp_q.size()), 64'd0);
      check($sformatf("vec%0d_speed", i), 64'(cap_if.speed), 64'(vecs[i].speed));
      check($sformatf("vec%0d_pulse_width", i), 64'(cap_if.pulse_width), 64'(vecs[i].pw));
      check($sformatf("vec%0d_period", i), 64'(cap_if.period), 64'(vecs[i].per));
      check($sformatf("vec%0d_signal_lost", i), 64'(cap_if.signal_lost), 64'd0);
    end

    // timeout: valid pulse, then input held low
    exp_q.push_back({8'd128, 32'd750});
    pulse(750, 1);
    lost_cyc = -1;
    for (int i = 0; i < TIMEOUT + 100; i++) begin
      @(negedge clk);
      if (cap_if.signal_lost === 1'b1) begin
        lost_cyc = cyc;
        break;
      end
    end
    check("timeout_cycle", 64'(lost_cyc), 64'(rise_cyc + LAT + TIMEOUT));
    check("timeout_speed_hold", 64'(cap_if.speed), 64'd128);
    check("timeout_width_hold", 64'(cap_if.pulse_width), 64'd750);
    check("timeout_period_hold", 64'(cap_if.period), 64'(PER_AFTER4));
    check("timeout_state", 64'(cap_if.state), 64'd0);
    check("timeout_pending", 64'(exp_q.size()), 64'd0);
    exp_q.push_back({8'd128, 32'd750});
    pulse(750, 1000);
    @(negedge clk);
    check("recover_pending", 64'(exp_q.size()), 64'd0);
    check("recover_signal_lost", 64'(cap_if.signal_lost), 64'd0);
    check("recover_period_hold", 64'(cap_if.period), 64'(PER_AFTER4));

    // reset in the middle of a pulse, held until the input has returned low
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (450) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    exp_q.push_back({8'd128, 32'd750});
    pulse(750, 1000);
    @(negedge clk);
    check("post_reset_pending", 64'(exp_q.size()), 64'd0);
    check("post_reset_width", 64'(cap_if.pulse_width), 64'd750);
    check("post_reset_period", 64'(cap_if.period), 64'd0);

    repeat (20) @(negedge clk);
    check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
